// File: rtl/sram_like_req_tracker_if.sv
// ============================================================================
// Module      : sram_like_req_tracker_if
// Description : Upstream request, response and SRAM-like bus signals of the
//               request tracker bundled as one interface.
//               slave  = tracker view, master = environment view.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sram_like_req_tracker_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // upstream request
  logic                  up_req_valid;
  logic                  up_req_ready;
  logic                  up_wr;
  logic [1:0]            up_size;
  logic [DATA_W/8-1:0]   up_wstrb;
  logic [ADDR_W-1:0]     up_addr;
  logic [DATA_W-1:0]     up_wdata;
  logic                  cancel;
  // response to consumer
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_wr;
  // SRAM-like bus
  logic                  req;
  logic                  wr;
  logic [1:0]            size;
  logic [DATA_W/8-1:0]   wstrb;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic                  addr_ok;
  logic                  data_ok;
  logic [DATA_W-1:0]     rdata;
  // status
  logic                  busy;

  modport slave (
    input  up_req_valid, up_wr, up_size, up_wstrb, up_addr, up_wdata, cancel,
    input  resp_ready, addr_ok, data_ok, rdata,
    output up_req_ready, resp_valid, resp_rdata, resp_wr,
    output req, wr, size, wstrb, addr, wdata, busy
  );

  modport master (
    output up_req_valid, up_wr, up_size, up_wstrb, up_addr, up_wdata, cancel,
    output resp_ready, addr_ok, data_ok, rdata,
    input  up_req_ready, resp_valid, resp_rdata, resp_wr,
    input  req, wr, size, wstrb, addr, wdata, busy
  );
endinterface

`default_nettype wire

// File: rtl/sram_like_req_tracker.sv
// ============================================================================
// Module      : sram_like_req_tracker
// Description : Outstanding-request tracker between a pipeline stage and an
//               SRAM-like req/addr_ok/data_ok bus. Up to MAX_OUTSTANDING
//               requests may be accepted but not yet consumed; responses are
//               buffered in order and cancel discards everything in flight.
//               Optional macro SRAM_LIKE_REQ_TRACKER_STATS_EN adds
//               issued/discarded/stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_like_req_tracker #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  wire logic              clk,
  input  wire logic              reset,
  sram_like_req_tracker_if.slave bus
`ifdef SRAM_LIKE_REQ_TRACKER_STATS_EN
  ,
  output logic [31:0]            o_stat_issued,
  output logic [31:0]            o_stat_discarded,
  output logic [31:0]            o_stat_stall
`endif
);

  localparam int c_CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int c_PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [c_PTR_W-1:0] c_LAST    = c_PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [c_CNT_W:0]   c_MAX_EXT = (c_CNT_W + 1)'(MAX_OUTSTANDING);

  // Ring pointers wrap at the depth, which need not be a power of two.
  function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] p);
    f_next = (p == c_LAST) ? '0 : p + 1'b1;
  endfunction

  // in-flight FIFO (wr bit per accepted request)
  logic               r_if_wr [MAX_OUTSTANDING];
  logic [c_PTR_W-1:0] r_if_wr_ptr;
  logic [c_PTR_W-1:0] r_if_rd_ptr;
  logic [c_CNT_W-1:0] r_inflight_cnt;
  logic [c_CNT_W-1:0] r_discard_cnt;

  // response FIFO ({wr, rdata})
  logic [DATA_W-1:0]  r_rf_data [MAX_OUTSTANDING];
  logic               r_rf_wr   [MAX_OUTSTANDING];
  logic [c_PTR_W-1:0] r_rf_wr_ptr;
  logic [c_PTR_W-1:0] r_rf_rd_ptr;
  logic [c_CNT_W-1:0] r_resp_cnt;

  logic w_credit;
  logic w_req;
  logic w_accept;
  logic w_dok;
  logic w_drop;
  logic w_rpush;
  logic w_rpop;
  logic w_resp_valid;

  // Stale in-flight entries still occupy a slot, so they count against credit.
  assign w_credit = ({1'b0, r_inflight_cnt} + {1'b0, r_resp_cnt}) < c_MAX_EXT;
  assign w_req    = bus.up_req_valid & w_credit & ~bus.cancel;
  assign w_accept = w_req & bus.addr_ok;

  // A data_ok with nothing in flight is a bus protocol error and is ignored.
  assign w_dok    = bus.data_ok & (r_inflight_cnt != '0);
  assign w_drop   = w_dok & (bus.cancel | (r_discard_cnt != '0));
  assign w_rpush  = w_dok & ~w_drop;

  assign w_resp_valid = (r_resp_cnt != '0);
  // A consumer pop during cancel is ignored since the FIFO is flushed anyway.
  assign w_rpop       = w_resp_valid & bus.resp_ready & ~bus.cancel;

  // bus request is a pure pass-through of the upstream fields
  assign bus.req          = w_req;
  assign bus.wr           = bus.up_wr;
  assign bus.size         = bus.up_size;
  assign bus.wstrb        = bus.up_wstrb;
  assign bus.addr         = bus.up_addr;
  assign bus.wdata        = bus.up_wdata;
  assign bus.up_req_ready = w_accept;

  // Head is masked when empty so idle outputs read as zero.
  assign bus.resp_valid = w_resp_valid;
  assign bus.resp_rdata = w_resp_valid ? r_rf_data[r_rf_rd_ptr] : '0;
  assign bus.resp_wr    = w_resp_valid ? r_rf_wr[r_rf_rd_ptr]   : 1'b0;
  assign bus.busy       = (r_inflight_cnt != '0) | w_resp_valid;

  // in-flight FIFO storage: record the store/load kind of each accept
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_if_wr[r_if_wr_ptr] <= bus.up_wr;
    end
  end

  // in-flight FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_if_wr_ptr    <= '0;
      r_if_rd_ptr    <= '0;
      r_inflight_cnt <= '0;
    end else begin
      if (w_accept) r_if_wr_ptr <= f_next(r_if_wr_ptr);
      if (w_dok)    r_if_rd_ptr <= f_next(r_if_rd_ptr);
      case ({w_accept, w_dok})
        2'b10:   r_inflight_cnt <= r_inflight_cnt + 1'b1;
        2'b01:   r_inflight_cnt <= r_inflight_cnt - 1'b1;
        default: r_inflight_cnt <= r_inflight_cnt;
      endcase
    end
  end

  // discard counter: cancel marks every remaining in-flight entry stale
  always_ff @(posedge clk) begin
    if (reset) begin
      r_discard_cnt <= '0;
    end else if (bus.cancel) begin
      r_discard_cnt <= r_inflight_cnt - c_CNT_W'(w_dok);
    end else if (w_drop) begin
      r_discard_cnt <= r_discard_cnt - 1'b1;
    end
  end

  // response FIFO storage: capture fresh bus data with its kind
  always_ff @(posedge clk) begin
    if (w_rpush) begin
      r_rf_data[r_rf_wr_ptr] <= bus.rdata;
      r_rf_wr[r_rf_wr_ptr]   <= r_if_wr[r_if_rd_ptr];
    end
  end

  // response FIFO pointers and occupancy; cancel flushes it
  always_ff @(posedge clk) begin
    if (reset || bus.cancel) begin
      r_rf_wr_ptr <= '0;
      r_rf_rd_ptr <= '0;
      r_resp_cnt  <= '0;
    end else begin
      if (w_rpush) r_rf_wr_ptr <= f_next(r_rf_wr_ptr);
      if (w_rpop)  r_rf_rd_ptr <= f_next(r_rf_rd_ptr);
      case ({w_rpush, w_rpop})
        2'b10:   r_resp_cnt <= r_resp_cnt + 1'b1;
        2'b01:   r_resp_cnt <= r_resp_cnt - 1'b1;
        default: r_resp_cnt <= r_resp_cnt;
      endcase
    end
  end

`ifdef SRAM_LIKE_REQ_TRACKER_STATS_EN
  logic [31:0] r_stat_issued;
  logic [31:0] r_stat_discarded;
  logic [31:0] r_stat_stall;

  // free-running statistics, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_issued    <= '0;
      r_stat_discarded <= '0;
      r_stat_stall     <= '0;
    end else begin
      if (w_accept) r_stat_issued    <= r_stat_issued + 1'b1;
      if (w_drop)   r_stat_discarded <= r_stat_discarded + 1'b1;
      if (bus.up_req_valid && !bus.cancel && !w_accept)
        r_stat_stall <= r_stat_stall + 1'b1;
    end
  end

  assign o_stat_issued    = r_stat_issued;
  assign o_stat_discarded = r_stat_discarded;
  assign o_stat_stall     = r_stat_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_like_req_tracker.sv
// ============================================================================
// Module      : tb_sram_like_req_tracker
// Description : Directed self-checking bench for sram_like_req_tracker with a
//               response scoreboard (MAX_OUTSTANDING = 2). Also checks the
//               statistics outputs when SRAM_LIKE_REQ_TRACKER_STATS_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_like_req_tracker;

  localparam int MAXO = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sram_like_req_tracker_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

`ifdef SRAM_LIKE_REQ_TRACKER_STATS_EN
  logic [31:0] st_issued, st_discarded, st_stall;
`endif

  sram_like_req_tracker #(
    .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
`ifdef SRAM_LIKE_REQ_TRACKER_STATS_EN
    ,
    .o_stat_issued    (st_issued),
    .o_stat_discarded (st_discarded),
    .o_stat_stall     (st_stall)
`endif
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          q_infl[$];   // wr bit per accepted, not yet returned request
  logic [32:0] sb[$];       // expected {wr, rdata} in delivery order
  int          m_resp = 0;  // responses sitting in the response buffer
  int          m_disc = 0;  // in-flight entries marked stale
  int          m_issued = 0, m_dropped = 0, m_stall = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic step(input logic v, input logic w, input logic [3:0] strb,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic cn, input logic aok, input logic dok,
                      input logic [31:0] rd, input logic rr);
    logic        exp_req, exp_rdy, wbit;
    logic [32:0] e;
    bus_if.up_req_valid = v;
    bus_if.up_wr        = w;
    bus_if.up_size      = 2'd2;
    bus_if.up_wstrb     = strb;
    bus_if.up_addr      = a;
    bus_if.up_wdata     = wd;
    bus_if.cancel       = cn;
    bus_if.addr_ok      = aok;
    bus_if.data_ok      = dok;
    bus_if.rdata        = rd;
    bus_if.resp_ready   = rr;
    @(negedge clk);
    exp_req = v & ~cn & ((q_infl.size() + m_resp) < MAXO);
    exp_rdy = exp_req & aok;
    chk("req",          bus_if.req,          exp_req);
    chk("up_req_ready", bus_if.up_req_ready, exp_rdy);
    chk("resp_valid",   bus_if.resp_valid,   m_resp != 0);
    chk("busy",         bus_if.busy,         (q_infl.size() != 0) || (m_resp != 0));
    chk("discard_cnt",  dut.r_discard_cnt,   m_disc);
    if (v) begin
      chk("bus_addr",  bus_if.addr,  a);
      chk("bus_wdata", bus_if.wdata, wd);
      chk("bus_wstrb", bus_if.wstrb, strb);
      chk("bus_wr",    bus_if.wr,    w);
    end
`ifdef SRAM_LIKE_REQ_TRACKER_STATS_EN
    chk("stat_issued",    st_issued,    m_issued);
    chk("stat_discarded", st_discarded, m_dropped);
    chk("stat_stall",     st_stall,     m_stall);
`endif
    // consumer handshake: compare head against scoreboard
    if (m_resp != 0 && rr && !cn && sb.size() != 0) begin
      e = sb.pop_front();
      chk("resp_rdata", bus_if.resp_rdata, e[31:0]);
      chk("resp_wr",    bus_if.resp_wr,    e[32]);
      m_resp--;
    end
    if (v && !cn && !exp_rdy) m_stall++;
    // bus response
    if (dok && q_infl.size() != 0) begin
      wbit = q_infl.pop_front();
      if (cn || m_disc > 0) begin
        m_dropped++;
        if (!cn) m_disc--;
      end else begin
        sb.push_back({wbit, rd});
        m_resp++;
      end
    end
    if (cn) begin
      m_resp = 0;
      sb.delete();
      m_disc = q_infl.size();
    end
    if (exp_rdy) begin
      q_infl.push_back(w);
      m_issued++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rr);
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, rr);
  endtask

  task automatic load(input logic [31:0] a, input logic rr);
    step(1'b1, 1'b0, 4'hF, a, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, rr);
  endtask

  task automatic resp(input logic [31:0] rd, input logic rr);
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, rd, rr);
  endtask

  initial begin
    reset = 1'b1;
    bus_if.up_req_valid = 1'b0; bus_if.up_wr = 1'b0; bus_if.up_size = 2'd2;
    bus_if.up_wstrb = 4'h0; bus_if.up_addr = '0; bus_if.up_wdata = '0;
    bus_if.cancel = 1'b0; bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b0;
    bus_if.rdata = '0; bus_if.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_resp_valid", bus_if.resp_valid, 1'b0);
    chk("rst_busy",       bus_if.busy,       1'b0);
    chk("rst_resp_rdata", bus_if.resp_rdata, 32'h0);
    chk("rst_resp_wr",    bus_if.resp_wr,    1'b0);
    @(posedge clk); #1;

    // single load, response visible the cycle after data_ok
    load(32'h1c00_0000, 1'b1);
    resp(32'h1234_5678, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // three back-to-back requests, only two accepted until credit frees
    load(32'h1c00_0010, 1'b1);
    load(32'h1c00_0014, 1'b1);
    load(32'h1c00_0018, 1'b1);
    step(1'b1, 1'b0, 4'hF, 32'h1c00_0018, 32'h0, 1'b0, 1'b1, 1'b1, 32'hA1, 1'b1);
    load(32'h1c00_0018, 1'b1);
    load(32'h1c00_0018, 1'b1);
    for (int k = 0; k < 8 && q_infl.size() != 0; k++) begin
      resp(32'hB0 + k, 1'b1);
      idle(1'b1);
    end
    chk("drain_done", q_infl.size(), 0);
    idle(1'b1);

    // cancel with two loads in flight: both returns dropped
    load(32'h1c00_0020, 1'b1);
    load(32'h1c00_0024, 1'b1);
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    resp(32'hAAAA_0000, 1'b1);
    resp(32'hBBBB_0000, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // cancel coinciding with data_ok, then a fresh request returns normally
    load(32'h1c00_0030, 1'b1);
    load(32'h1c00_0034, 1'b1);
    step(1'b1, 1'b0, 4'hF, 32'h1c00_0038, 32'h0, 1'b1, 1'b1, 1'b1, 32'hDEAD, 1'b1);
    resp(32'hBEEF, 1'b1);
    load(32'h1c00_0040, 1'b1);
    resp(32'h55, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // back-pressure: buffer fills, then drains in order
    load(32'h1c00_0050, 1'b0);
    load(32'h1c00_0054, 1'b0);
    resp(32'h11, 1'b0);
    resp(32'h22, 1'b0);
    load(32'h1c00_0058, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // store pass-through and store response
    step(1'b1, 1'b1, 4'b0011, 32'h1c00_0004, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    resp(32'h0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // stray data_ok with nothing in flight is ignored
    resp(32'h9999, 1'b1);
    idle(1'b1);
    idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // absolute runaway guard
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
